// File: rtl/tournament_btb.sv
// Set-associative BTB with a tournament (bimodal / gshare / meta chooser) direction predictor.
// Lookup is combinational from fetch_pc; commits train the tables and land on the next clock edge.
module tournament_btb #(
    parameter int SETS      = 64,
    parameter int WAYS      = 4,
    parameter int GHR_BITS  = 10,
    parameter int META_BITS = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_valid,
    input  logic [31:0]         fetch_pc,
    output logic                pred_hit,
    output logic                pred_taken,
    output logic [31:0]         pred_target,
    output logic [GHR_BITS-1:0] pred_ghr,
    output logic                pred_sel,
    input  logic                commit_valid,
    input  logic [31:0]         commit_pc,
    input  logic                commit_is_br,
    input  logic                commit_is_jal,
    input  logic                commit_taken,
    input  logic [31:0]         commit_target,
    input  logic [GHR_BITS-1:0] commit_ghr,
    input  logic                commit_mispredict
);
    localparam int SET_W = $clog2(SETS);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_W = 30 - SET_W;
    localparam int BIM_N = 1 << META_BITS;
    localparam int PHT_N = 1 << GHR_BITS;

    logic [WAYS-1:0]     r_valid [SETS];
    logic [WAYS-1:0]     r_jal   [SETS];
    logic [TAG_W-1:0]    r_tag   [SETS][WAYS];
    logic [31:0]         r_tgt   [SETS][WAYS];
    logic [WAY_W-1:0]    r_rr    [SETS];
    logic [1:0]          r_bim   [BIM_N];
    logic [1:0]          r_meta  [BIM_N];
    logic [1:0]          r_pht   [PHT_N];
    logic [GHR_BITS-1:0] r_ghr;

    function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
        if (up) return (c == 2'd3) ? c : c + 2'd1;
        else    return (c == 2'd0) ? c : c - 2'd1;
    endfunction

    logic                 w_unused_bits;
    logic [SET_W-1:0]     w_f_set, w_c_set;
    logic [TAG_W-1:0]     w_f_tag, w_c_tag;
    logic                 w_f_hit, w_c_hit, w_c_inv_found;
    logic [WAY_W-1:0]     w_f_way, w_c_way, w_c_inv_way, w_c_vict, w_c_wr_way, w_rr_next;
    logic [META_BITS-1:0] w_f_bidx, w_c_bidx;
    logic [GHR_BITS-1:0]  w_f_gidx, w_c_gidx;
    logic                 w_f_jal, w_f_dir;
    logic                 w_c_br, w_c_ctl, w_c_alloc, w_c_wr, w_b_ok, w_g_ok;

    assign w_unused_bits = ^{fetch_pc[1:0], commit_pc[1:0]};
    assign w_f_set  = fetch_pc[SET_W+1:2];
    assign w_f_tag  = fetch_pc[31:SET_W+2];
    assign w_c_set  = commit_pc[SET_W+1:2];
    assign w_c_tag  = commit_pc[31:SET_W+2];
    assign w_f_bidx = fetch_pc[META_BITS+1:2];
    assign w_c_bidx = commit_pc[META_BITS+1:2];
    assign w_f_gidx = r_ghr ^ fetch_pc[GHR_BITS+1:2];
    assign w_c_gidx = commit_ghr ^ commit_pc[GHR_BITS+1:2];

    always_comb begin
        w_f_hit       = 1'b0;
        w_f_way       = '0;
        w_c_hit       = 1'b0;
        w_c_way       = '0;
        w_c_inv_found = 1'b0;
        w_c_inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_f_hit && r_valid[w_f_set][w] && r_tag[w_f_set][w] == w_f_tag) begin
                w_f_hit = 1'b1;
                w_f_way = WAY_W'(w);
            end
            if (!w_c_hit && r_valid[w_c_set][w] && r_tag[w_c_set][w] == w_c_tag) begin
                w_c_hit = 1'b1;
                w_c_way = WAY_W'(w);
            end
            if (!w_c_inv_found && !r_valid[w_c_set][w]) begin
                w_c_inv_found = 1'b1;
                w_c_inv_way   = WAY_W'(w);
            end
        end
    end

    // Chooser picks gshare once the meta counter reaches the weakly-gshare half.
    assign w_f_jal = r_jal[w_f_set][w_f_way];
    assign w_f_dir = w_f_jal | (r_meta[w_f_bidx][1] ? r_pht[w_f_gidx][1] : r_bim[w_f_bidx][1]);

    assign pred_hit    = w_f_hit & ~rst;
    assign pred_taken  = pred_hit & w_f_dir;
    assign pred_target = pred_taken ? r_tgt[w_f_set][w_f_way] : fetch_pc + 32'd4;
    assign pred_ghr    = rst ? '0 : r_ghr;
    assign pred_sel    = ~rst & r_meta[w_f_bidx][1];

    // A commit flagged both br and jal is handled as a jal.
    assign w_c_br     = commit_is_br & ~commit_is_jal;
    assign w_c_ctl    = commit_valid & (commit_is_br | commit_is_jal);
    assign w_c_alloc  = w_c_ctl & ~w_c_hit & (commit_is_jal | commit_taken);
    assign w_c_vict   = w_c_inv_found ? w_c_inv_way : r_rr[w_c_set];
    assign w_c_wr     = w_c_ctl & (w_c_hit | w_c_alloc);
    assign w_c_wr_way = w_c_hit ? w_c_way : w_c_vict;
    assign w_rr_next  = (r_rr[w_c_set] == WAY_W'(WAYS - 1)) ? '0 : r_rr[w_c_set] + WAY_W'(1);
    assign w_b_ok     = (r_bim[w_c_bidx][1] == commit_taken);
    assign w_g_ok     = (r_pht[w_c_gidx][1] == commit_taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
            for (int i = 0; i < BIM_N; i++) begin
                r_bim[i]  <= 2'd1;
                r_meta[i] <= 2'd1;
            end
            for (int i = 0; i < PHT_N; i++) r_pht[i] <= 2'd1;
            r_ghr <= '0;
        end else begin
            // Mispredict recovery wins over the speculative shift from the same cycle.
            if (w_c_ctl && commit_mispredict)
                r_ghr <= w_c_br ? {commit_ghr[GHR_BITS-2:0], commit_taken} : commit_ghr;
            else if (fetch_valid && w_f_hit && !w_f_jal)
                r_ghr <= {r_ghr[GHR_BITS-2:0], w_f_dir};
            if (w_c_alloc) begin
                r_valid[w_c_set][w_c_vict] <= 1'b1;
                if (!w_c_inv_found) r_rr[w_c_set] <= w_rr_next;
            end
            if (commit_valid && w_c_br) begin
                r_bim[w_c_bidx] <= sat2(r_bim[w_c_bidx], commit_taken);
                r_pht[w_c_gidx] <= sat2(r_pht[w_c_gidx], commit_taken);
                if (w_g_ok && !w_b_ok)
                    r_meta[w_c_bidx] <= sat2(r_meta[w_c_bidx], 1'b1);
                else if (!w_g_ok && w_b_ok)
                    r_meta[w_c_bidx] <= sat2(r_meta[w_c_bidx], 1'b0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_c_wr) begin
            r_tag[w_c_set][w_c_wr_way] <= w_c_tag;
            r_tgt[w_c_set][w_c_wr_way] <= commit_target;
            r_jal[w_c_set][w_c_wr_way] <= commit_is_jal;
        end
    end

endmodule

// File: tb/tb_tournament_btb.sv
// Scoreboard bench for tournament_btb: stimulus queues expected lookups, a negedge monitor checks them.
module tb_tournament_btb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        pred_hit, pred_taken, pred_sel;
    logic [31:0] pred_target;
    logic [9:0]  pred_ghr;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc = '0;
    logic        commit_is_br = 1'b0;
    logic        commit_is_jal = 1'b0;
    logic        commit_taken = 1'b0;
    logic [31:0] commit_target = '0;
    logic [9:0]  commit_ghr = '0;
    logic        commit_mispredict = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       nm;
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic [9:0]  ghr;
        logic        sel;
        int          kind;
        int          idx;
        int          val;
    } exp_t;
    exp_t sbq[$];

    tournament_btb dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .pred_ghr(pred_ghr), .pred_sel(pred_sel),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_is_br(commit_is_br), .commit_is_jal(commit_is_jal),
        .commit_taken(commit_taken), .commit_target(commit_target),
        .commit_ghr(commit_ghr), .commit_mispredict(commit_mispredict)
    );

    always #5 clk = ~clk;

    task automatic expect_lookup(input string nm, input logic h, input logic t, input logic [31:0] tg,
                                 input logic [9:0] g, input logic s,
                                 input int k = 0, input int ix = 0, input int v = 0);
        exp_t e;
        e.nm = nm; e.hit = h; e.taken = t; e.tgt = tg; e.ghr = g; e.sel = s;
        e.kind = k; e.idx = ix; e.val = v;
        sbq.push_back(e);
    endtask

    task automatic cyc(input logic fv, input logic [31:0] fpc,
                       input logic cv, input logic [31:0] cpc, input logic br, input logic jal,
                       input logic tk, input logic [31:0] ctgt, input logic [9:0] cghr, input logic mp);
        fetch_valid = fv; fetch_pc = fpc;
        commit_valid = cv; commit_pc = cpc; commit_is_br = br; commit_is_jal = jal;
        commit_taken = tk; commit_target = ctgt; commit_ghr = cghr; commit_mispredict = mp;
        @(posedge clk); #1;
        fetch_valid = 1'b0; commit_valid = 1'b0; commit_mispredict = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        cyc(1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 10'h0, 1'b0);
    endtask

    task automatic commit_br(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic [9:0] g);
        cyc(1'b0, 32'h0, 1'b1, pc, 1'b1, 1'b0, tk, tg, g, 1'b0);
    endtask

    // Monitor: every presented fetch consumes one scoreboard entry.
    initial begin
        exp_t e;
        int   act;
        forever begin
            @(negedge clk);
            if (fetch_valid) begin
                n_tests++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_fetch pc=%h: no expected entry queued", fetch_pc);
                end else begin
                    e = sbq.pop_front();
                    if ({pred_hit, pred_taken, pred_target, pred_ghr, pred_sel} !==
                        {e.hit, e.taken, e.tgt, e.ghr, e.sel}) begin
                        n_fail++;
                        $display("FAIL %s: got hit=%b taken=%b tgt=%h ghr=%h sel=%b, want hit=%b taken=%b tgt=%h ghr=%h sel=%b",
                                 e.nm, pred_hit, pred_taken, pred_target, pred_ghr, pred_sel,
                                 e.hit, e.taken, e.tgt, e.ghr, e.sel);
                    end
                    if (e.kind != 0) begin
                        n_tests++;
                        case (e.kind)
                            1:       act = int'(dut.r_meta[e.idx]);
                            2:       act = int'(dut.r_bim[e.idx]);
                            default: act = int'(dut.r_rr[e.idx]);
                        endcase
                        if (act != e.val) begin
                            n_fail++;
                            $display("FAIL %s_state: got %0d, want %0d", e.nm, act, e.val);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk); #1;
        expect_lookup("in_reset", 1'b0, 1'b0, 32'h104, 10'h0, 1'b0);
        fetch(32'h100);
        rst = 1'b0;
        expect_lookup("post_reset", 1'b0, 1'b0, 32'h104, 10'h0, 1'b0, 1, 'h40, 1);
        fetch(32'h100);

        cyc(1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h800, 10'h0, 1'b0);
        expect_lookup("jal_hit", 1'b1, 1'b1, 32'h800, 10'h0, 1'b0);
        fetch(32'h200);
        expect_lookup("jal_no_shift", 1'b0, 1'b0, 32'h108, 10'h0, 1'b0);
        fetch(32'h104);

        commit_br(32'h300, 1'b1, 32'h340, 10'h0);
        commit_br(32'h300, 1'b1, 32'h340, 10'h0);
        expect_lookup("br_trained", 1'b1, 1'b1, 32'h340, 10'h0, 1'b0, 2, 'hC0, 3);
        fetch(32'h300);
        expect_lookup("br_shift_in_1", 1'b0, 1'b0, 32'h108, 10'h1, 1'b0);
        fetch(32'h104);

        for (int i = 1; i <= 5; i++)
            commit_br(32'h1004 + 32'(i - 1) * 32'h1000, 1'b1, 32'h9000 + 32'(i) * 32'h10, 10'h0);
        expect_lookup("evicted_miss", 1'b0, 1'b0, 32'h1008, 10'h1, 1'b0, 3, 1, 1);
        fetch(32'h1004);
        expect_lookup("new_way0_hit", 1'b1, 1'b1, 32'h9050, 10'h1, 1'b0);
        fetch(32'h5004);
        expect_lookup("way1_kept", 1'b1, 1'b1, 32'h9020, 10'h3, 1'b0);
        fetch(32'h2004);

        expect_lookup("spec_shift1", 1'b1, 1'b1, 32'h340, 10'h007, 1'b0);
        fetch(32'h300);
        expect_lookup("spec_shift2", 1'b1, 1'b1, 32'h340, 10'h00F, 1'b0);
        fetch(32'h300);
        expect_lookup("spec_shift3", 1'b1, 1'b1, 32'h340, 10'h01F, 1'b0);
        fetch(32'h300);
        expect_lookup("fetch_with_recover", 1'b1, 1'b1, 32'h340, 10'h03F, 1'b0);
        cyc(1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 32'h340, 10'h2A5, 1'b1);
        expect_lookup("ghr_recovered", 1'b0, 1'b0, 32'h108, 10'h14A, 1'b0);
        fetch(32'h104);

        commit_br(32'h408, 1'b1, 32'h500, 10'h057);
        commit_br(32'h408, 1'b1, 32'h500, 10'h1A8);
        commit_br(32'h400, 1'b1, 32'h480, 10'h055);
        expect_lookup("meta_to_2", 1'b0, 1'b0, 32'h1404, 10'h14A, 1'b1, 1, 'h100, 2);
        fetch(32'h1400);
        commit_br(32'h400, 1'b0, 32'h480, 10'h233);
        expect_lookup("meta_to_3", 1'b0, 1'b0, 32'h1404, 10'h14A, 1'b1, 1, 'h100, 3);
        fetch(32'h1400);
        commit_br(32'h400, 1'b1, 32'h480, 10'h1AA);
        expect_lookup("meta_sat_a", 1'b0, 1'b0, 32'h1404, 10'h14A, 1'b1, 1, 'h100, 3);
        fetch(32'h1400);
        commit_br(32'h400, 1'b0, 32'h480, 10'h2CC);
        expect_lookup("meta_sat_b", 1'b0, 1'b0, 32'h1404, 10'h14A, 1'b1, 1, 'h100, 3);
        fetch(32'h1400);

        for (int i = 0; i < 5; i++) commit_br(32'h600, 1'b0, 32'h680, 10'h0);
        expect_lookup("bim_sat_0", 1'b0, 1'b0, 32'h604, 10'h14A, 1'b0, 2, 'h180, 0);
        fetch(32'h600);
        commit_br(32'h600, 1'b1, 32'h680, 10'h0);
        expect_lookup("bim_from_0_nt", 1'b1, 1'b0, 32'h604, 10'h14A, 1'b0, 2, 'h180, 1);
        fetch(32'h600);
        expect_lookup("shift_in_0", 1'b0, 1'b0, 32'h108, 10'h294, 1'b0);
        fetch(32'h104);

        rst = 1'b1;
        expect_lookup("mid_reset_out", 1'b0, 1'b0, 32'h204, 10'h0, 1'b0);
        cyc(1'b1, 32'h200, 1'b1, 32'h700, 1'b0, 1'b1, 1'b1, 32'h900, 10'h0, 1'b0);
        rst = 1'b0;
        expect_lookup("reset_cleared", 1'b0, 1'b0, 32'h204, 10'h0, 1'b0, 1, 'h100, 1);
        fetch(32'h200);
        expect_lookup("reset_beat_commit", 1'b0, 1'b0, 32'h704, 10'h0, 1'b0);
        fetch(32'h700);

        repeat (2) @(posedge clk);
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tournament_btb.md
TOURNAMENT_BTB -- requirements
Module: tournament_btb

Interface
REQ-001 SHALL have parameter SETS, default 64, meaning the number of BTB sets (power of two, at least 2).
REQ-002 SHALL have parameter WAYS, default 4, meaning the BTB associativity (power of two, 1 to 8).
REQ-003 SHALL have parameter GHR_BITS, default 10, meaning the global history length; the gshare PHT has 2**GHR_BITS entries.
REQ-004 SHALL have parameter META_BITS, default 10, meaning the index width of the bimodal and meta tables (2**META_BITS entries each).
REQ-005 SHALL have port clk, input, 1 bit: the single clock. All state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port fetch_valid, input, 1 bit: a fetch lookup is presented this cycle.
REQ-008 SHALL have port fetch_pc, input, 32 bits: the fetch address (word-aligned).
REQ-009 SHALL have port pred_hit, output, 1 bit: tag hit in the BTB.
REQ-010 SHALL have port pred_taken, output, 1 bit: predicted taken.
REQ-011 SHALL have port pred_target, output, 32 bits: predicted next PC.
REQ-012 SHALL have port pred_ghr, output, GHR_BITS bits: GHR snapshot that travels with the instruction.
REQ-013 SHALL have port pred_sel, output, 1 bit: chooser selection, 0 = bimodal, 1 = gshare.
REQ-014 SHALL have port commit_valid, input, 1 bit: a resolved control instruction retires.
REQ-015 SHALL have port commit_pc, input, 32 bits: PC of the retiring instruction.
REQ-016 SHALL have port commit_is_br, input, 1 bit: conditional branch.
REQ-017 SHALL have port commit_is_jal, input, 1 bit: unconditional direct jump.
REQ-018 SHALL have port commit_taken, input, 1 bit: the resolved direction.
REQ-019 SHALL have port commit_target, input, 32 bits: the resolved target.
REQ-020 SHALL have port commit_ghr, input, GHR_BITS bits: the pred_ghr captured at fetch.
REQ-021 SHALL have port commit_mispredict, input, 1 bit: the direction or target was wrong; the front end is flushed.

Function
REQ-022 Lookup SHALL be combinational from fetch_pc; set = fetch_pc[log2(SETS)+1:2], tag = the remaining upper PC bits. pred_hit = any valid way with an equal tag.
REQ-023 Direction on a hit SHALL be as follows.
- Entry jal: always taken.
- Entry br: bimodal counter[1] if meta < 2, else gshare counter[1].
- Bimodal and meta index: pc[META_BITS+1:2].
- Gshare index: GHR ^ pc[GHR_BITS+1:2].
REQ-024 pred_target SHALL be the entry target when pred_hit && pred_taken, else fetch_pc+4 (mod 2**32); on a miss, pred_taken = 0.
REQ-025 Speculative GHR SHALL update as follows.
- Default: when fetch_valid && pred_hit && the entry is br, GHR <= {GHR[GHR_BITS-2:0], pred_taken}.
- jal or miss: no shift.
- pred_ghr = GHR value before the shift.
REQ-026 On commit_valid && commit_mispredict, GHR SHALL be restored as follows.
- commit_is_br: GHR <= {commit_ghr[GHR_BITS-2:0], commit_taken}.
- Otherwise: GHR <= commit_ghr.
- Recovery takes priority over a same-cycle fetch shift.
REQ-027 Each 2-bit counter update SHALL saturate at 0 and 3; there is no wrap.
REQ-028 On commit_valid && commit_is_br, the counters SHALL update as follows.
- Bimodal[commit_pc idx] moves toward commit_taken.
- Gshare[commit_ghr ^ commit_pc idx] moves toward commit_taken.
- Meta moves +1 only if gshare's pre-update prediction is correct and bimodal's is wrong; −1 on the converse; otherwise unchanged.
REQ-029 On commit_valid && (commit_is_br || commit_is_jal) with a tag hit, the way's target SHALL be rewritten with commit_target and its type bit with commit_is_jal.
REQ-030 On commit_valid && (commit_is_br || commit_is_jal) with a tag miss, allocation SHALL be as follows.
- Allocate a way only if commit_is_jal || commit_taken.
- Victim: the lowest-index invalid way, else the set's round-robin pointer.
- The pointer advances (mod WAYS) only when a valid way is evicted.
REQ-031 commit_is_br and commit_is_jal both high SHALL be treated as jal; commit_valid with neither SHALL change no state.
REQ-032 A same-cycle fetch and commit to the same entry or counter SHALL see pre-commit state at fetch; the commit update lands at the clock edge.
REQ-033 Latency SHALL be 0 cycles for the prediction and 1 cycle for a commit to become visible to lookups.

Reset
REQ-034 While rst is high, the block SHALL do the following.
- All valid bits, GHR and round-robin pointers cleared.
- Bimodal and gshare counters set to 1 (weakly not-taken); meta set to 1 (weak bimodal).
- Outputs for any fetch_pc: pred_hit 0, pred_taken 0, pred_target fetch_pc+4, pred_ghr 0, pred_sel 0.
REQ-035 Reset asserted mid-operation SHALL override all same-cycle commit and fetch updates.

Verification
REQ-036 The bench SHALL cover the post-reset lookup: rst 1 cycle, fetch_pc 0x100 -> pred_hit 0, pred_taken 0, pred_target 0x104, pred_ghr 0.
REQ-037 The bench SHALL cover jal allocate and hit: commit jal pc 0x200 target 0x800 -> next cycle fetch 0x200 gives hit 1, taken 1, target 0x800, GHR unchanged.
REQ-038 The bench SHALL cover branch training: 2 taken commits of br pc 0x300 target 0x340 -> bimodal = 3; fetch 0x300 gives taken 1, target 0x340, GHR shifts in 1.
REQ-039 The bench SHALL cover WAYS+1 taken branches mapping to one set.
- Expected: ways fill 0..WAYS-1; the next evicts way 0 and the pointer becomes 1; the first PC then misses.
REQ-040 The bench SHALL cover mispredict recovery: after 3 speculative shifts, commit br mispredict with commit_ghr 0x2A5 and taken 0, simultaneous with a fetch hit.
- Expected: GHR = 0x14A (GHR_BITS 10); the fetch shift is dropped.
REQ-041 The bench SHALL cover saturation and meta.
- Drive gshare correct and bimodal wrong 4 times: meta 1->2->3->3; pred_sel becomes 1 after the first update.
- Drive 5 not-taken commits: the counter saturates at 0.
